// File: rtl/rv_pkg.sv
// Shared types for the boot loader: FSM state encoding and word geometry.
package rv_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream handshake plus control/status strobes between a host and the boot loader.
interface boot_loader_if;

    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_write;
    logic       busy;
    logic       done;
    logic       err;

    modport slave (
        input  start,
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_write,
        output busy,
        output done,
        output err
    );

    modport master (
        output start,
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_write,
        input  busy,
        input  done,
        input  err
    );

endinterface

// File: rtl/word_packer.sv
// Shifts bytes little-endian into a 32-bit word; clear zero-fills unused upper bytes.
// Latency: word_nxt_o/full_o are combinational on the offered byte; no backpressure of its own.
module word_packer
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [31:0] word_nxt_o,
    output logic        full_o
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [31:0] word_nxt;

    always_comb begin
        word_nxt = word_q;
        word_nxt[{idx_q, 3'b000} +: 8] = byte_i;
        word_d = word_q;
        idx_d  = idx_q;
        // clear wins so the byte that completes a length field is not carried into data
        if (clear_i) begin
            word_d = '0;
            idx_d  = '0;
        end else if (shift_i) begin
            word_d = word_nxt;
            idx_d  = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o     = word_q;
    assign word_nxt_o = word_nxt;
    assign full_o     = shift_i && (idx_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/boot_loader.sv
// Receives a length-prefixed byte image and writes it as 32-bit words onto a shared tristate bus.
// Latency: one WRITE cycle per word, DONE one cycle later; in_ready drops during WRITE/DONE/ERR.
module boot_loader
    import rv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic         clk,
    input  logic         rst,
    boot_loader_if.slave lif,
    inout  wire  [31:0]  addr,
    inout  wire  [31:0]  bus
);

    state_e      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] off_q, off_d;
    logic        err_q, err_d;

    logic        fire;
    logic        pk_clear;
    logic        pk_full;
    logic [31:0] pk_word;
    logic [31:0] pk_word_nxt;

    assign fire = lif.in_valid && lif.in_ready;

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (pk_clear),
        .shift_i    (fire),
        .byte_i     (lif.in_data),
        .word_o     (pk_word),
        .word_nxt_o (pk_word_nxt),
        .full_o     (pk_full)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        off_d    = off_q;
        err_d    = err_q;
        pk_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lif.start) begin
                    state_d  = ST_LEN;
                    cnt_d    = '0;
                    off_d    = '0;
                    err_d    = 1'b0;
                    pk_clear = 1'b1;
                end
            end
            ST_LEN: begin
                // the packer doubles as the length assembler; its 4th byte completes the count
                if (fire && pk_full) begin
                    pk_clear = 1'b1;
                    len_d    = pk_word_nxt;
                    if (pk_word_nxt == 32'd0) begin
                        state_d = ST_DONE;
                    end else if (pk_word_nxt > 32'(MEM_BYTES)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (fire) begin
                    cnt_d = cnt_q + 32'd1;
                    if (pk_full || (cnt_d == len_q)) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                pk_clear = 1'b1;
                off_d    = off_q + 32'(WORD_BYTES);
                state_d  = (cnt_q == len_q) ? ST_DONE : ST_DATA;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            off_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            err_q   <= err_d;
        end
    end

    assign lif.in_ready  = (state_q == ST_LEN) || (state_q == ST_DATA);
    assign lif.mem_write = (state_q == ST_WRITE);
    assign lif.busy      = (state_q != ST_IDLE);
    assign lif.done      = (state_q == ST_DONE);
    assign lif.err       = err_q;

    // the bus is shared with the CPU, so it is released in every state but WRITE
    assign addr = (state_q == ST_WRITE) ? (BASE_ADDR + off_q) : 'z;
    assign bus  = (state_q == ST_WRITE) ? pk_word : 'z;

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader: normal, partial-word, empty, oversize, gapped and reset-abort loads.
module tb_boot_loader;

    logic        clk;
    logic        rst;
    wire  [31:0] addr;
    wire  [31:0] bus;

    boot_loader_if lif ();

    boot_loader #(
        .BASE_ADDR (32'h0),
        .MEM_BYTES (4096)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .lif  (lif),
        .addr (addr),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int w0;

    wire addr_is_z = (addr === 32'hzzzz_zzzz);
    wire bus_is_z  = (bus  === 32'hzzzz_zzzz);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (lif.mem_write === 1'b1) wr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        lif.in_valid = 1'b1;
        lif.in_data  = b;
        while (!lif.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk("in_ready_wait", {31'd0, lif.in_ready}, 32'd1);
        else @(negedge clk);
        lif.in_valid = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] len);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        send_byte(len[23:16]);
        send_byte(len[31:24]);
    endtask

    task automatic pulse_start();
        lif.start = 1'b1;
        @(negedge clk);
        lif.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        lif.start    = 1'b0;
        lif.in_valid = 1'b0;
        lif.in_data  = 8'h00;
        #2;
        chk("rst_in_ready",  {31'd0, lif.in_ready},  32'd0);
        chk("rst_mem_write", {31'd0, lif.mem_write}, 32'd0);
        chk("rst_busy",      {31'd0, lif.busy},      32'd0);
        chk("rst_done",      {31'd0, lif.done},      32'd0);
        chk("rst_err",       {31'd0, lif.err},       32'd0);
        chk("rst_addr_z",    {31'd0, addr_is_z},     32'd1);
        chk("rst_bus_z",     {31'd0, bus_is_z},      32'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", {31'd0, lif.busy}, 32'd0);

        // length 8, bytes 01..08
        w0 = wr_cnt;
        pulse_start();
        chk("t1_busy",     {31'd0, lif.busy},     32'd1);
        chk("t1_in_ready", {31'd0, lif.in_ready}, 32'd1);
        send_len(32'd8);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        chk("t1_w0_we",   {31'd0, lif.mem_write}, 32'd1);
        chk("t1_w0_addr", addr, 32'h0000_0000);
        chk("t1_w0_bus",  bus,  32'h0403_0201);
        for (int i = 5; i <= 8; i++) send_byte(8'(i));
        chk("t1_w1_we",   {31'd0, lif.mem_write}, 32'd1);
        chk("t1_w1_addr", addr, 32'h0000_0004);
        chk("t1_w1_bus",  bus,  32'h0807_0605);
        tick();
        chk("t1_done",    {31'd0, lif.done},      32'd1);
        chk("t1_done_we", {31'd0, lif.mem_write}, 32'd0);
        tick();
        chk("t1_done_low", {31'd0, lif.done}, 32'd0);
        chk("t1_idle",     {31'd0, lif.busy}, 32'd0);
        chk("t1_addr_z",   {31'd0, addr_is_z}, 32'd1);
        chk("t1_bus_z",    {31'd0, bus_is_z},  32'd1);
        chk("t1_writes",   32'(wr_cnt - w0), 32'd2);

        // length 5, partial final word
        w0 = wr_cnt;
        pulse_start();
        send_len(32'd5);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        chk("t2_w0_addr", addr, 32'h0000_0000);
        chk("t2_w0_bus",  bus,  32'hDDCC_BBAA);
        send_byte(8'hEE);
        chk("t2_w1_we",   {31'd0, lif.mem_write}, 32'd1);
        chk("t2_w1_addr", addr, 32'h0000_0004);
        chk("t2_w1_bus",  bus,  32'h0000_00EE);
        tick();
        chk("t2_done", {31'd0, lif.done}, 32'd1);
        tick();
        chk("t2_writes", 32'(wr_cnt - w0), 32'd2);

        // length 0
        w0 = wr_cnt;
        pulse_start();
        send_len(32'd0);
        chk("t3_done", {31'd0, lif.done},      32'd1);
        chk("t3_we",   {31'd0, lif.mem_write}, 32'd0);
        tick();
        chk("t3_busy", {31'd0, lif.busy}, 32'd0);
        chk("t3_done_low", {31'd0, lif.done}, 32'd0);
        chk("t3_writes", 32'(wr_cnt - w0), 32'd0);

        // length 4100 exceeds MEM_BYTES
        w0 = wr_cnt;
        pulse_start();
        send_len(32'd4100);
        chk("t4_err",      {31'd0, lif.err},       32'd1);
        chk("t4_we",       {31'd0, lif.mem_write}, 32'd0);
        chk("t4_in_ready", {31'd0, lif.in_ready},  32'd0);
        tick();
        chk("t4_idle",     {31'd0, lif.busy},      32'd0);
        chk("t4_err_stky", {31'd0, lif.err},       32'd1);
        chk("t4_writes",   32'(wr_cnt - w0), 32'd0);
        pulse_start();
        chk("t4_err_clr",  {31'd0, lif.err},  32'd0);
        chk("t4_busy",     {31'd0, lif.busy}, 32'd1);
        send_len(32'd0);
        tick();

        // in_valid every other cycle, plus an ignored start mid-DATA
        w0 = wr_cnt;
        pulse_start();
        send_len(32'd8);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i));
            if (i == 4) begin
                chk("t5_w0_addr", addr, 32'h0000_0000);
                chk("t5_w0_bus",  bus,  32'h0403_0201);
            end
            if (i == 8) begin
                chk("t5_w1_addr", addr, 32'h0000_0004);
                chk("t5_w1_bus",  bus,  32'h0807_0605);
            end else begin
                lif.start = (i == 5);
                tick();
                lif.start = 1'b0;
                if (i == 2) begin
                    chk("t5_gap_addr_z", {31'd0, addr_is_z}, 32'd1);
                    chk("t5_gap_bus_z",  {31'd0, bus_is_z},  32'd1);
                end
            end
        end
        tick();
        chk("t5_done", {31'd0, lif.done}, 32'd1);
        tick();
        chk("t5_writes", 32'(wr_cnt - w0), 32'd2);

        // reset after 6 of 8 data bytes
        w0 = wr_cnt;
        pulse_start();
        send_len(32'd8);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        chk("t6_w0_bus", bus, 32'h0403_0201);
        send_byte(8'h05);
        send_byte(8'h06);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy",  {31'd0, lif.busy},      32'd0);
        chk("t6_rst_ready", {31'd0, lif.in_ready},  32'd0);
        chk("t6_rst_we",    {31'd0, lif.mem_write}, 32'd0);
        chk("t6_rst_done",  {31'd0, lif.done},      32'd0);
        chk("t6_rst_err",   {31'd0, lif.err},       32'd0);
        chk("t6_rst_addr_z", {31'd0, addr_is_z},    32'd1);
        chk("t6_rst_bus_z",  {31'd0, bus_is_z},     32'd1);
        tick();
        rst = 1'b0;
        lif.in_valid = 1'b1;
        lif.in_data  = 8'h07;
        repeat (3) tick();
        chk("t6_no_restart_ready", {31'd0, lif.in_ready}, 32'd0);
        chk("t6_no_restart_busy",  {31'd0, lif.busy},     32'd0);
        lif.in_valid = 1'b0;
        chk("t6_writes", 32'(wr_cnt - w0), 32'd1);
        pulse_start();
        chk("t6_restart_busy", {31'd0, lif.busy}, 32'd1);
        send_len(32'd0);
        chk("t6_restart_done", {31'd0, lif.done}, 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0, byte address of the first word written.
REQ-002 SHALL have parameter MEM_BYTES, default 4096, maximum image length accepted.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a load, honoured only in IDLE.
REQ-006 SHALL have port in_valid, input, 1, a byte is offered on in_data.
REQ-007 SHALL have port in_data, input, 8, the offered image byte.
REQ-008 SHALL have port in_ready, output, 1, the loader accepts the byte this cycle.
REQ-009 SHALL have port addr, inout, 32, shared address bus, driven only in WRITE and 'z otherwise.
REQ-010 SHALL have port bus, inout, 32, shared data bus, driven only in WRITE and 'z otherwise.
REQ-011 SHALL have port mem_write, output, 1, memory write strobe.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE; the CPU is held in reset by this signal.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on successful completion.
REQ-014 SHALL have port err, output, 1, sticky error flag, cleared by the next accepted start.

Function
REQ-015 SHALL implement the states IDLE, LEN, DATA, WRITE, DONE, ERR.
REQ-016 SHALL transfer a byte only on a rising edge with in_valid and in_ready both high; in_ready is high only in LEN and DATA.
REQ-017 SHALL move IDLE->LEN on start, clearing the byte counter, the word offset and err.
REQ-018 SHALL assemble 4 bytes in LEN as a little-endian byte count, the first byte going to bits 7:0.
REQ-019 SHALL, after the 4th length byte, go to DONE if the length is 0, to ERR if the length exceeds MEM_BYTES, and to DATA otherwise.
REQ-020 SHALL pack DATA bytes little-endian into a 32-bit word and go to WRITE after the 4th byte of a word or after the final image byte.
REQ-021 SHALL zero-fill the unused upper bytes of a partial final word.
REQ-022 SHALL, in WRITE (exactly one cycle), drive addr = BASE_ADDR + word offset, bus = the packed word and mem_write = 1.
REQ-023 SHALL then advance the offset by 4 and return to DATA, or go to DONE if all bytes have been consumed.
REQ-024 SHALL, in DONE, assert done for one cycle and then return to IDLE.
REQ-025 SHALL, in ERR, set err, perform no further writes, and return to IDLE on the next cycle.
REQ-026 SHALL ignore start outside IDLE.
REQ-027 SHALL compute address arithmetic modulo 2^32.
REQ-028 SHALL keep the byte count at 32 bits and make no lengths beyond MEM_BYTES reachable.
REQ-029 SHALL have a minimum latency from last byte accepted to done of 2 cycles (WRITE, then DONE).

Reset
REQ-030 SHALL, while rst is high, force state=IDLE, in_ready=0, mem_write=0, busy=0, done=0, err=0, addr='z and bus='z, independent of clk.
REQ-031 SHALL, when reset is asserted mid-load, abandon the partially packed word and never write it.
REQ-032 SHALL require a new start after reset release before any load begins.

Structure
REQ-033 SHALL place the state enum and WORD_BYTES=4 in shared package rv_pkg.
REQ-034 SHALL use one sub-module, word_packer (byte shift-in, byte index, zero-fill, full flag); the FSM and bus drive remain in boot_loader.

Verification
REQ-035 Bench SHALL cover: start, then length 8, then bytes 01..08 -> write 32'h04030201 @0, then 32'h08070605 @4, then done one cycle after the second WRITE.
REQ-036 Bench SHALL cover: length 5, bytes AA BB CC DD EE -> writes 32'hDDCCBBAA @0 and 32'h000000EE @4.
REQ-037 Bench SHALL cover: length 0 -> no mem_write, done pulse, busy low afterward.
REQ-038 Bench SHALL cover: length 4100 with MEM_BYTES=4096 -> err=1, no mem_write, IDLE; the next start clears err.
REQ-039 Bench SHALL cover: in_valid toggling every other cycle during DATA -> the same writes as in the gapless run, with addr/bus 'z outside WRITE.
REQ-040 Bench SHALL cover: rst pulsed after 6 of 8 data bytes -> only the @0 write occurs, outputs at reset values, and start is required again.
